// File: rtl/alu_cmd_seq.sv
// Command FIFO feeding a registered ALU interface, with a three-state issue/hold
// sequencer that captures one result at a time for a ready/valid consumer.
module alu_cmd_seq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [3:0] cmd_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_r,
    input  logic       alu_e,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_r,
    output logic       res_e,
    output logic [3:0] res_op,
    output logic       res_err,
    output logic       busy,
    output logic [7:0] res_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      mem_a_q [DEPTH];
    logic [7:0]      mem_a_d [DEPTH];
    logic [7:0]      mem_b_q [DEPTH];
    logic [7:0]      mem_b_d [DEPTH];
    logic [3:0]      mem_op_q [DEPTH];
    logic [3:0]      mem_op_d [DEPTH];
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_r_q, res_r_d;
    logic            res_e_q, res_e_d;
    logic [3:0]      res_op_q, res_op_d;
    logic            res_err_q, res_err_d;
    logic [7:0]      res_count_q, res_count_d;
    logic            push;
    logic            pop;

    assign cmd_ready = (cnt_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && (cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        mem_a_d     = mem_a_q;
        mem_b_d     = mem_b_q;
        mem_op_d    = mem_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_r_d     = res_r_q;
        res_e_d     = res_e_q;
        res_op_d    = res_op_q;
        res_err_d   = res_err_q;
        res_count_d = res_count_q;

        if (push) begin
            mem_a_d[wr_ptr_q]  = cmd_a;
            mem_b_d[wr_ptr_q]  = cmd_b;
            mem_op_d[wr_ptr_q] = cmd_op;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    alu_a_d  = mem_a_q[rd_ptr_q];
                    alu_b_d  = mem_b_q[rd_ptr_q];
                    alu_op_d = mem_op_q[rd_ptr_q];
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                res_op_d    = alu_op_q;
                res_valid_d = 1'b1;
                // Divide by zero: ALU output is meaningless, report a saturated result.
                if (alu_op_q == 4'd3 && alu_b_q == 8'd0) begin
                    res_r_d   = 8'hFF;
                    res_e_d   = 1'b0;
                    res_err_d = 1'b1;
                end else begin
                    res_r_d   = alu_r;
                    res_e_d   = (alu_op_q == 4'd0 || alu_op_q == 4'd1) ? alu_e : 1'b0;
                    res_err_d = 1'b0;
                end
                state_d = StHold;
            end
            StHold: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_count_d = res_count_q + 8'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_r_q     <= '0;
            res_e_q     <= 1'b0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_r_q     <= res_r_d;
            res_e_q     <= res_e_d;
            res_op_q    <= res_op_d;
            res_err_q   <= res_err_d;
            res_count_q <= res_count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        mem_a_q  <= mem_a_d;
        mem_b_q  <= mem_b_d;
        mem_op_q <= mem_op_d;
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_r     = res_r_q;
    assign res_e     = res_e_q;
    assign res_op    = res_op_q;
    assign res_err   = res_err_q;
    assign res_count = res_count_q;
    assign busy      = (cnt_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Randomized and directed bench for alu_cmd_seq against a queue-based transaction model.
module tb_alu_cmd_seq;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_r;
    logic       alu_e;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_r;
    logic       res_e;
    logic [3:0] res_op;
    logic       res_err;
    logic       busy;
    logic [7:0] res_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model: FIFO contents, the command in flight and its phase (0 waiting, 1 issued, 2 held).
    cmd_t       m_fifo[$];
    cmd_t       m_cur;
    cmd_t       m_alu;
    int         m_phase;
    logic [7:0] m_count;
    int         total_done;
    logic [7:0] got_r[$];
    logic       got_e[$];
    logic       got_err[$];

    alu_cmd_seq #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r     (alu_r),
        .alu_e     (alu_e),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_r     (res_r),
        .res_e     (res_e),
        .res_op    (res_op),
        .res_err   (res_err),
        .busy      (busy),
        .res_count (res_count)
    );

    always #5 clk = ~clk;

    // External ALU; deliberately sets the extra bit on ops whose carry must be masked.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return (b == 8'd0) ? 9'h1AA : {1'b0, a / b};
            4'd4:    return {1'b1, a | b};
            4'd15:   return (a < b) ? 9'h001 : 9'h000;
            default: return {a[0], a ^ b};
        endcase
    endfunction

    assign {alu_e, alu_r} = alu_fn(alu_a, alu_b, alu_op);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: predict from pre-edge inputs, advance the model, compare after the edge.
    task automatic step();
        bit         acc;
        logic [8:0] fn;
        logic [7:0] exp_r;
        logic       exp_e;
        logic       exp_err;
        check_eq("cmd_ready", 32'(cmd_ready), 32'(m_fifo.size() < DEPTH));
        acc = cmd_valid && (m_fifo.size() < DEPTH);
        if (!rst && res_valid && res_ready) begin
            got_r.push_back(res_r);
            got_e.push_back(res_e);
            got_err.push_back(res_err);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_fifo.delete();
            m_phase = 0;
            m_count = '0;
            m_alu   = '0;
        end else begin
            if (m_phase == 2) begin
                if (res_ready) begin
                    m_phase = 0;
                    m_count++;
                    total_done++;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_fifo.size() > 0) begin
                m_cur   = m_fifo.pop_front();
                m_alu   = m_cur;
                m_phase = 1;
            end
            if (acc) m_fifo.push_back('{cmd_a, cmd_b, cmd_op});
        end
        check_eq("res_valid", 32'(res_valid), 32'(m_phase == 2));
        check_eq("busy", 32'(busy), 32'(m_fifo.size() > 0 || m_phase != 0));
        check_eq("res_count", 32'(res_count), 32'(m_count));
        check_eq("alu_cmd", 32'({alu_a, alu_b, alu_op}), 32'(m_alu));
        if (m_phase == 2) begin
            fn = alu_fn(m_cur.a, m_cur.b, m_cur.op);
            if (m_cur.op == 4'd3 && m_cur.b == 8'd0) begin
                exp_r   = 8'hFF;
                exp_e   = 1'b0;
                exp_err = 1'b1;
            end else begin
                exp_r   = fn[7:0];
                exp_e   = (m_cur.op <= 4'd1) ? fn[8] : 1'b0;
                exp_err = 1'b0;
            end
            check_eq("res_r", 32'(res_r), 32'(exp_r));
            check_eq("res_e", 32'(res_e), 32'(exp_e));
            check_eq("res_op", 32'(res_op), 32'(m_cur.op));
            check_eq("res_err", 32'(res_err), 32'(exp_err));
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic rdy, input logic r);
        cmd_valid = v;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        res_ready = rdy;
        rst       = r;
        step();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 4'h0, rdy, 1'b0);
    endtask

    initial begin
        int   idx;
        int   start;
        cmd_t seq[6];

        m_fifo.delete();
        m_phase    = 0;
        m_count    = '0;
        m_alu      = '0;
        total_done = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_op     = '0;
        res_ready  = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1);
        check_eq("rst_res", 32'({res_r, res_e, res_op, res_err}), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);

        // Single add with carry and exact latency.
        drive(1'b1, 8'hF0, 8'h20, 4'd0, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        step();
        check_eq("add_alu_a", 32'(alu_a), 32'hF0);
        step();
        check_eq("add_valid", 32'(res_valid), 32'd1);
        check_eq("add_r", 32'(res_r), 32'h10);
        check_eq("add_e", 32'(res_e), 32'd1);
        step();
        check_eq("add_count", 32'(res_count), 32'd1);

        // Divide by zero then a normal divide; carry then masked op 4.
        got_r.delete();
        got_e.delete();
        got_err.delete();
        drive(1'b1, 8'h37, 8'h00, 4'd3, 1'b1, 1'b0);
        drive(1'b1, 8'h64, 8'h05, 4'd3, 1'b1, 1'b0);
        drive(1'b1, 8'hFF, 8'h01, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 8'h12, 8'h34, 4'd4, 1'b1, 1'b0);
        idle(12, 1'b1);
        check_eq("dir_n", 32'(got_r.size()), 32'd4);
        check_eq("div0_r", 32'(got_r[0]), 32'hFF);
        check_eq("div0_err", 32'(got_err[0]), 32'd1);
        check_eq("div_r", 32'(got_r[1]), 32'h14);
        check_eq("div_err", 32'(got_err[1]), 32'd0);
        check_eq("carry_e", 32'(got_e[2]), 32'd1);
        check_eq("mask_e", 32'(got_e[3]), 32'd0);

        // Backpressure: six commands offered, only five fit while results are held.
        for (int i = 0; i < 6; i++) seq[i] = '{8'(i * 17 + 3), 8'(i + 1), 4'(i % 3)};
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = 1'b1;
            cmd_a     = seq[idx].a;
            cmd_b     = seq[idx].b;
            cmd_op    = seq[idx].op;
            res_ready = 1'b0;
            rst       = 1'b0;
            if (m_fifo.size() < DEPTH && idx < 5) idx++;
            step();
        end
        check_eq("full_ready", 32'(cmd_ready), 32'd0);
        check_eq("full_accepted", 32'(idx), 32'd5);
        idle(20, 1'b1);
        check_eq("drain_ready", 32'(cmd_ready), 32'd1);

        // Reset while holding a result with three queued.
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(i), 8'h02, 4'd1, 1'b0, 1'b0);
        idle(2, 1'b0);
        check_eq("pre_rst_hold", 32'(res_valid), 32'd1);
        drive(1'b1, 8'hAA, 8'hBB, 4'd2, 1'b1, 1'b1);
        check_eq("rst_valid", 32'(res_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready2", 32'(cmd_ready), 32'd1);
        idle(10, 1'b1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 99) == 0));
        end

        // 256 completions from reset bring the counter back to zero.
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1);
        start = total_done;
        for (int c = 0; c < 1500 && (total_done - start) < 256; c++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
        end
        check_eq("wrap_done", 32'(total_done - start), 32'd256);
        check_eq("wrap_count", 32'(res_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001: DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: cmd_valid  input  1  command offered.
REQ-005: cmd_ready  output  1  FIFO can accept a command.
REQ-006: cmd_a  input  8  operand A.
REQ-007: cmd_b  input  8  operand B.
REQ-008: cmd_op  input  4  ALU opcode 0..15.
REQ-009: alu_a  output  8  registered operand A to ALU.
REQ-010: alu_b  output  8  registered operand B to ALU.
REQ-011: alu_op  output  4  registered opcode to ALU.
REQ-012: alu_r  input  8  ALU combinational result.
REQ-013: alu_e  input  1  ALU carry/borrow/extra bit.
REQ-014: res_valid  output  1  result held for consumer.
REQ-015: res_ready  input  1  consumer accepts result.
REQ-016: res_r  output  8  captured result.
REQ-017: res_e  output  1  captured carry/borrow.
REQ-018: res_op  output  4  opcode that produced the result.
REQ-019: res_err  output  1  divide-by-zero flag.
REQ-020: busy  output  1  high when FIFO non-empty or FSM not IDLE.
REQ-021: res_count  output  8  count of results consumed, wraps 255 -> 0.

Function
REQ-022: Command accepted on an edge where cmd_valid and cmd_ready are both high; written to FIFO tail.
REQ-023: cmd_ready SHALL equal (FIFO occupancy < DEPTH); no write when full; cmd_valid with cmd_ready low has no effect and command stays with producer.
REQ-024: FSM states IDLE, ISSUE, HOLD.
REQ-025: IDLE: if FIFO non-empty, pop head, load alu_a/alu_b/alu_op from it, go ISSUE; else stay.
REQ-026: ISSUE (exactly one cycle): capture into res_r/res_e/res_op/res_err, set res_valid, go HOLD.
REQ-027: HOLD: res_* stable while res_valid high and res_ready low; on res_ready high, clear res_valid, increment res_count, go IDLE.
REQ-028: Latency: command accepted at edge N into empty FIFO with FSM IDLE -> alu_* loaded at edge N+1 -> res_valid high after edge N+2.
REQ-029: Throughput: one result per 3 cycles max when res_ready held high (IDLE, ISSUE, HOLD each one cycle).
REQ-030: FIFO push and pop on the same edge SHALL both take effect; occupancy unchanged; FIFO order strictly preserved.
REQ-031: Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty from a separate occupancy count 0..DEPTH.
REQ-032: res_e SHALL equal alu_e for opcodes 0 and 1, and 0 for all other opcodes.
REQ-033: Opcode 3 with alu_b = 0: res_err=1, res_r=8'hFF, res_e=0, alu_r ignored; otherwise res_err=0.
REQ-034: Opcode 15: res_r = alu_r unchanged (0 or 1); no width extension or masking by this block.
REQ-035: alu_a/alu_b/alu_op hold last issued values in HOLD and IDLE until next pop.

Reset
REQ-036: rst high at an edge: FSM IDLE, FIFO empty, pointers and occupancy 0, res_valid 0, res_r/res_e/res_op/res_err 0, alu_a/alu_b/alu_op 0, res_count 0, busy 0, cmd_ready 1 the following cycle.
REQ-037: rst mid-operation (any state, any occupancy) SHALL discard queued and in-flight commands; no res_valid produced for them; rst overrides a simultaneous cmd handshake or res_ready.

Verification
REQ-038: Single add: cmd a=8'hF0 b=8'h20 op=0 at edge N, res_ready=1 -> res_valid after N+2, res_r=8'h10, res_e=1, res_op=0, res_count 1 after N+3.
REQ-039: Divide by zero: a=8'h37 b=0 op=3 -> res_err=1, res_r=8'hFF, res_e=0; then a=8'h64 b=8'h05 op=3 -> res_r=8'h14, res_err=0.
REQ-040: Backpressure/full: res_ready=0, push 5 commands back-to-back with DEPTH=4 -> first popped, next 4 fill FIFO, cmd_ready low, 6th held; release res_ready -> results in order, cmd_ready rises.
REQ-041: Carry masking: op=4 preceded by op=0 with carry -> res_e=0 for op 4.
REQ-042: Reset in HOLD with 3 queued -> res_valid 0, busy 0, cmd_ready 1 next cycle; no further results.
REQ-043: res_count wrap: 256 completed results -> res_count returns to 0.
